// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM states, delay counter
// width and the iteration counter width rule.
package div_unit_pkg;

    localparam int DLY_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_WAIT,
        DIV_CALC,
        DIV_FIX
    } div_state_t;

    function automatic int div_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Operand/config/result bundle of the divider functional unit.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              run;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic              sign_en;
    logic [DLY_W-1:0]  delay0;
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic              busy;
    logic              done;

    modport master (
        output run, in0, in1, sign_en, delay0,
        input  out0, out1, busy, done
    );

    modport slave (
        input  run, in0, in1, sign_en, delay0,
        output out0, out1, busy, done
    );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the
// divisor magnitude and keep the difference when it is non-negative.
module div_unit_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] dvsr,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);
    // rem_in < dvsr always holds, so the shifted value needs one extra bit
    logic [DATA_W:0] shifted;

    assign shifted = {rem_in, dvd_bit};
    assign q_bit   = (shifted >= {1'b0, dvsr});
    assign rem_out = q_bit ? DATA_W'(shifted - {1'b0, dvsr}) : shifted[DATA_W-1:0];
endmodule

// File: rtl/div_unit.sv
// Iterative integer divider: optional capture delay, DATA_W restoring steps,
// then a sign fix-up cycle that writes quotient/remainder and pulses done.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = div_cnt_w(DATA_W);

    div_state_t        state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [CNT_W-1:0]  it_q, it_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dvsr_q, dvsr_d;
    logic [DATA_W-1:0] out0_q, out0_d;
    logic [DATA_W-1:0] out1_q, out1_d;
    logic              sgn_q, sgn_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] step_rem;
    logic              step_q;
    logic              cap_sgn, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    div_unit_step #(.DATA_W(DATA_W)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[DATA_W-1]),
        .dvsr    (dvsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // With no delay the operands are captured on the run edge itself, so the
    // live sign_en applies; otherwise the value latched at run is used.
    assign cap_sgn = (state_q == DIV_IDLE) ? bus.sign_en : sgn_q;
    assign a_neg   = cap_sgn & bus.in0[DATA_W-1];
    assign b_neg   = cap_sgn & bus.in1[DATA_W-1];
    assign a_mag   = a_neg ? -bus.in0 : bus.in0;
    assign b_mag   = b_neg ? -bus.in1 : bus.in1;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        it_d      = it_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvsr_d    = dvsr_q;
        out0_d    = out0_q;
        out1_d    = out1_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (bus.run && !done_q) begin
                    sgn_d = bus.sign_en;
                    if (bus.delay0 == '0) begin
                        state_d = DIV_CALC;
                    end else begin
                        dly_d   = bus.delay0;
                        state_d = DIV_WAIT;
                    end
                end
            end
            DIV_WAIT: begin
                dly_d = dly_q - DLY_W'(1);
                if (dly_q == DLY_W'(1)) state_d = DIV_CALC;
            end
            DIV_CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[DATA_W-2:0], step_q};
                it_d  = it_q - CNT_W'(1);
                if (it_q == CNT_W'(1)) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                out0_d  = dz_q ? '1 : (neg_quo_q ? -dvd_q : dvd_q);
                out1_d  = neg_rem_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase

        // Operand capture happens on whichever edge enters CALC.
        if (state_d == DIV_CALC && state_q != DIV_CALC) begin
            rem_d     = '0;
            dvd_d     = a_mag;
            dvsr_d    = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = (bus.in1 == '0);
            it_d      = CNT_W'(DATA_W);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            dly_q     <= '0;
            it_q      <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvsr_q    <= '0;
            out0_q    <= '0;
            out1_q    <= '0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            it_q      <= it_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvsr_q    <= dvsr_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
            sgn_q     <= sgn_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign bus.out0 = out0_q;
    assign bus.out1 = out1_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != DIV_IDLE) | done_q;
endmodule

// File: tb/tb_div_unit.sv
// Randomised self-checking bench for div_unit against a plain-arithmetic
// quotient/remainder model, plus directed corner cases.
module tb_div_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_unit_if #(.DATA_W(W)) bus ();

    div_unit #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference: truncating division on 64-bit integers with the defined corners.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sgn,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
    endfunction

    task automatic scramble_operands();
        bus.in0 = $urandom;
        bus.in1 = $urandom;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int dly, input string tag);
        logic [W-1:0] eq, er;
        int n;
        ref_div(a, b, sgn, eq, er);
        bus.run = 1'b1; bus.in0 = a; bus.in1 = b; bus.sign_en = sgn; bus.delay0 = dly;
        @(posedge clk); #1;
        n = 0;
        bus.run = 1'b0;
        bus.sign_en = ~sgn;
        bus.delay0  = $urandom;
        if (dly == 0) scramble_operands();
        while (bus.done !== 1'b1 && n < dly + 40) begin
            check({tag, "_busy"}, W'(bus.busy), W'(1));
            bus.run = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
            if (n == dly) scramble_operands();
        end
        check({tag, "_latency"}, W'(n), W'(dly + W + 1));
        check({tag, "_done"}, W'(bus.done), W'(1));
        check({tag, "_busy_done"}, W'(bus.busy), W'(1));
        check({tag, "_quo"}, bus.out0, eq);
        check({tag, "_rem"}, bus.out1, er);
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        check({tag, "_done_pulse"}, W'(bus.done), W'(0));
        check({tag, "_run_in_done"}, W'(bus.busy), W'(0));
        check({tag, "_hold"}, bus.out0, eq);
    endtask

    function automatic logic [W-1:0] pick_a();
        case ($urandom_range(0, 5))
            0: return MIN;
            1: return '0;
            2: return W'($urandom_range(0, 20));
            3: return -W'($urandom_range(1, 20));
            4: return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_b();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return '1;
            3: return W'($urandom_range(2, 20));
            4: return -W'($urandom_range(2, 20));
            5: return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] vals[0:50];
        logic [W-1:0] eq, er, got_q, got_r;
        int dones, done_edge, busy_bad;

        bus.run = 1'b0; bus.in0 = '0; bus.in1 = '0; bus.sign_en = 1'b0; bus.delay0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", bus.out0, '0);
        check("rst_out1", bus.out1, '0);
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_done", W'(bus.done), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", W'(bus.busy), W'(0));

        do_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
        do_op(-32'd100, 32'd7, 1'b1, 0, "sm100_7");
        do_op(32'd100, -32'd7, 1'b1, 0, "s100_m7");
        do_op(32'h1234, 32'd0, 1'b0, 0, "div0");
        do_op(-32'h1234, 32'd0, 1'b1, 0, "sdiv0");
        do_op(MIN, '1, 1'b1, 0, "ovf");
        do_op('1, 32'd2, 1'b0, 0, "umax_2");
        do_op(MIN, 32'd3, 1'b1, 2, "smin_3");
        do_op(32'd77, 32'd5, 1'b0, 65537, "long_dly");

        // delay0=5 with in0 changing every cycle and a second run ignored
        bus.sign_en = 1'b0; bus.delay0 = 5; bus.in1 = 32'd13;
        dones = 0; done_edge = -1; busy_bad = 0; got_q = '0; got_r = '0;
        for (int e = 0; e <= 50; e++) begin
            bus.in0 = $urandom;
            vals[e] = bus.in0;
            bus.run = (e == 0 || e == 10);
            @(posedge clk); #1;
            if (e >= 10 && e < 38 && bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                dones++;
                done_edge = e;
                got_q = bus.out0;
                got_r = bus.out1;
            end
        end
        bus.run = 1'b0;
        ref_div(vals[5], 32'd13, 1'b0, eq, er);
        check("dly5_dones", W'(dones), W'(1));
        check("dly5_edge", W'(done_edge), W'(5 + W + 1));
        check("dly5_busy", W'(busy_bad), W'(0));
        check("dly5_quo", got_q, eq);
        check("dly5_rem", got_r, er);

        // reset in the middle of CALC
        bus.run = 1'b1; bus.in0 = 32'd999; bus.in1 = 32'd4; bus.sign_en = 1'b0; bus.delay0 = 0;
        @(posedge clk); #1;
        bus.run = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out0", bus.out0, '0);
        check("mid_rst_out1", bus.out1, '0);
        check("mid_rst_busy", W'(bus.busy), W'(0));
        check("mid_rst_done", W'(bus.done), W'(0));
        #2 rst = 1'b0;
        dones = 0; busy_bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) dones++;
            if (bus.busy !== 1'b0) busy_bad++;
        end
        check("post_rst_no_done", W'(dones), W'(0));
        check("post_rst_no_busy", W'(busy_bad), W'(0));
        do_op(32'd999, 32'd4, 1'b0, 0, "after_rst");

        for (int i = 0; i < 150; i++) begin
            do_op(pick_a(), pick_b(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
